minterm_extractor: RTL and testbench

//  Inverse of the SoP function blocks. Sweeps an N-input combinational function

---
 rtl/minterm_extractor.sv | 140 ++++++++++++++
 tb/tb_minterm_extractor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_extractor.sv
// Sweeps an N_IN-input combinational function through every input vector,
// rebuilds its minterm mask and streams the set minterm indices over valid/ready.
module minterm_extractor #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    output logic [N_IN-1:0]        fut_in_o,
    input  logic                   fut_s_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [(1<<N_IN)-1:0]   mask_o,
    output logic [N_IN:0]          ones_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [N_IN-1:0]        m_index_o,
    output logic                   m_last_o
);

    localparam int unsigned    MW          = 1 << N_IN;
    localparam int unsigned    CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN:0]  LAST_IDX    = (N_IN+1)'(MW - 1);
    localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [N_IN:0]   idx_q, idx_d;
    logic [N_IN:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]   mask_q, mask_d;
    logic [N_IN:0]   ones_q, ones_d;
    logic [N_IN-1:0] fut_q, fut_d;
    logic [N_IN-1:0] hi_bit;
    logic            cur_set;

    assign cur_set = mask_q[ptr_q[N_IN-1:0]];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        ones_d  = ones_q;
        fut_d   = fut_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mask_d  = '0;
                    ones_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    fut_d   = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                mask_d[idx_q[N_IN-1:0]] = fut_s_i;
                ones_d = ones_q + {{N_IN{1'b0}}, fut_s_i};
                if (idx_q == LAST_IDX) begin
                    ptr_d   = '0;
                    state_d = S_EMIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    fut_d   = idx_q[N_IN-1:0] + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_EMIT: begin
                // Clear bits are skipped in one cycle; set bits wait for the handshake.
                if (!cur_set || m_ready_i) begin
                    if (ptr_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            ones_q  <= '0;
            fut_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            ones_q  <= ones_d;
            fut_q   <= fut_d;
        end
    end

    // Highest set minterm, used to flag the final index of the stream.
    always_comb begin
        hi_bit = '0;
        for (int unsigned i = 0; i < MW; i++) begin
            if (mask_q[i]) hi_bit = i[N_IN-1:0];
        end
    end

    assign fut_in_o  = fut_q;
    assign busy_o    = (state_q == S_DRIVE) || (state_q == S_SAMPLE) || (state_q == S_EMIT);
    assign done_o    = (state_q == S_DONE);
    assign mask_o    = mask_q;
    assign ones_o    = ones_q;
    assign m_valid_o = (state_q == S_EMIT) && cur_set;
    assign m_index_o = ptr_q[N_IN-1:0];
    assign m_last_o  = m_valid_o && (ptr_q[N_IN-1:0] == hi_bit);

endmodule

// File: tb/tb_minterm_extractor.sv
// Bench for minterm_extractor: table vectors, random functions against a
// truth-table model, plus reset-mid-sweep and start-noise sequences.
module tb_minterm_extractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] fut_tab = '0;

    logic        start_a, start_b;
    logic [3:0]  fut_in_a, fut_in_b;
    logic        fut_s_a, fut_s_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [15:0] mask_a, mask_b;
    logic [4:0]  ones_a, ones_b;
    logic        valid_a, valid_b, last_a, last_b;
    logic [3:0]  index_a, index_b;

    logic        w_busy, w_done, w_valid, w_last;
    logic [3:0]  w_fut_in, w_index;
    logic [15:0] w_mask;
    logic [4:0]  w_ones;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign fut_s_a = fut_tab[fut_in_a];
    assign fut_s_b = fut_tab[fut_in_b];

    assign w_busy   = sel ? busy_b   : busy_a;
    assign w_done   = sel ? done_b   : done_a;
    assign w_valid  = sel ? valid_b  : valid_a;
    assign w_last   = sel ? last_b   : last_a;
    assign w_fut_in = sel ? fut_in_b : fut_in_a;
    assign w_index  = sel ? index_b  : index_a;
    assign w_mask   = sel ? mask_b   : mask_a;
    assign w_ones   = sel ? ones_b   : ones_a;

    minterm_extractor #(.N_IN(4), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .fut_in_o(fut_in_a),
        .fut_s_i(fut_s_a), .busy_o(busy_a), .done_o(done_a), .mask_o(mask_a),
        .ones_o(ones_a), .m_valid_o(valid_a), .m_ready_i(ready),
        .m_index_o(index_a), .m_last_o(last_a)
    );

    minterm_extractor #(.N_IN(4), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .fut_in_o(fut_in_b),
        .fut_s_i(fut_s_b), .busy_o(busy_b), .done_o(done_b), .mask_o(mask_b),
        .ones_o(ones_b), .m_valid_o(valid_b), .m_ready_i(ready),
        .m_index_o(index_b), .m_last_o(last_b)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int popcount(input logic [15:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) if (v[i]) c++;
        return c;
    endfunction

    // mode: 0 = ready high, 1 = ready toggling 1010.., 2 = random ready
    task automatic run(input string tag, input bit dsel, input logic [15:0] f, input int mode,
                       input bit noise, input logic [15:0] xm, input logic [4:0] xo);
        int s, sweep, e, done_e, first_v, fut_bad, busy_bad, stab_bad, exp_fin;
        bit fin, stall_pend;
        logic [3:0] stall_idx;
        int exp_q[$];
        int got_q[$];
        bit lst_q[$];
        s = dsel ? 3 : 1;
        sweep = (s + 1) * 16;
        for (int i = 0; i < 16; i++) if (xm[i]) exp_q.push_back(i);
        fin = 0; stall_pend = 0; stall_idx = '0;
        done_e = -1; first_v = -1; fut_bad = 0; busy_bad = 0; stab_bad = 0;
        @(negedge clk);
        sel = dsel;
        fut_tab = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0;
        // e counts rising edges since the one that accepted start
        while (!fin && e < 1000) begin
            if (w_done) begin
                fin = 1;
                done_e = e;
            end else begin
                if (!w_busy) busy_bad++;
                exp_fin = (e < sweep) ? e / (s + 1) : 15;
                if (w_fut_in != 4'(exp_fin)) fut_bad++;
                if (stall_pend && (!w_valid || w_index != stall_idx)) stab_bad++;
                if (w_valid && first_v < 0) first_v = e;
                case (mode)
                    0: ready = 1'b1;
                    1: ready = (e % 2 == 0);
                    default: ready = 1'($urandom_range(0, 1));
                endcase
                stall_pend = 0;
                if (w_valid) begin
                    if (ready) begin
                        got_q.push_back(int'(w_index));
                        lst_q.push_back(w_last);
                    end else begin
                        stall_pend = 1;
                        stall_idx = w_index;
                    end
                end
                start = noise && (e == 5 || e == sweep + 3);
                @(negedge clk);
                e++;
            end
        end
        start = 1'b0;
        check({tag, "/done_seen"}, 64'(fin), 64'd1);
        if (fin) begin
            check({tag, "/mask"}, 64'(w_mask), 64'(xm));
            check({tag, "/ones"}, 64'(w_ones), 64'(xo));
            check({tag, "/busy_at_done"}, 64'(w_busy), 64'd0);
            check({tag, "/hs_count"}, 64'(got_q.size()), 64'(exp_q.size()));
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
                check({tag, "/hs_index"}, 64'(got_q[k]), 64'(exp_q[k]));
                check({tag, "/hs_last"}, 64'(lst_q[k]), 64'(k == exp_q.size() - 1));
            end
            check({tag, "/fut_in_seq"}, 64'(fut_bad), 64'd0);
            check({tag, "/busy_seq"}, 64'(busy_bad), 64'd0);
            check({tag, "/stall_stable"}, 64'(stab_bad), 64'd0);
            // With ready high, done lands (SETTLE+1)*16 + 16 edges after the accept edge
            if (mode == 0) check({tag, "/done_time"}, 64'(done_e), 64'(sweep + 16));
            if (xm[0]) check({tag, "/emit_entry"}, 64'(first_v), 64'(sweep));
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, "/start_in_done"}, 64'(w_busy), 64'd0);
            check({tag, "/done_pulse"}, 64'(w_done), 64'd0);
            check({tag, "/mask_hold"}, 64'(w_mask), 64'(xm));
        end
    endtask

    typedef struct {
        string       tag;
        bit          dsel;
        logic [15:0] f;
        int          mode;
        bit          noise;
        logic [15:0] xm;
        logic [4:0]  xo;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rf;
        int w;
        bit hit;
        tbl[0] = '{"T1",      1'b0, 16'hAC3C, 0, 1'b0, 16'hAC3C, 5'd8};
        tbl[1] = '{"T2",      1'b0, 16'h0000, 0, 1'b0, 16'h0000, 5'd0};
        tbl[2] = '{"T3",      1'b0, 16'hFFFF, 1, 1'b0, 16'hFFFF, 5'd16};
        tbl[3] = '{"T4",      1'b0, 16'hAC3C, 0, 1'b1, 16'hAC3C, 5'd8};
        tbl[4] = '{"T1rnd",   1'b0, 16'hAC3C, 2, 1'b0, 16'hAC3C, 5'd8};
        tbl[5] = '{"T6",      1'b1, 16'h1235, 0, 1'b0, 16'h1235, 5'd6};
        tbl[6] = '{"T6tog",   1'b1, 16'hAC3C, 1, 1'b1, 16'hAC3C, 5'd8};

        #23;
        check("reset/busy", 64'(busy_a), 64'd0);
        check("reset/mask", 64'(mask_a), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run(tbl[i].tag, tbl[i].dsel, tbl[i].f, tbl[i].mode, tbl[i].noise, tbl[i].xm, tbl[i].xo);

        // Reset asserted mid-sweep at vector 7, then a clean rerun
        @(negedge clk);
        sel = 1'b0;
        fut_tab = 16'hAC3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (fut_in_a == 4'd7) hit = 1;
            else @(negedge clk);
        end
        check("T5/reach_idx7", 64'(hit), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("T5/busy",    64'(busy_a),   64'd0);
        check("T5/done",    64'(done_a),   64'd0);
        check("T5/mask",    64'(mask_a),   64'd0);
        check("T5/ones",    64'(ones_a),   64'd0);
        check("T5/fut_in",  64'(fut_in_a), 64'd0);
        check("T5/m_valid", 64'(valid_a),  64'd0);
        check("T5/m_index", 64'(index_a),  64'd0);
        check("T5/m_last",  64'(last_a),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("T5/idle", 64'(busy_a), 64'd0);
        run("T5rerun", 1'b0, 16'hAC3C, 0, 1'b0, 16'hAC3C, 5'd8);

        // Random functions: the mask equals the truth table, ones its popcount
        for (int k = 0; k < 12; k++) begin
            rf = 16'($urandom);
            w = popcount(rf);
            run("RND", 1'($urandom_range(0, 1)), rf, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                rf, 5'(w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
